// File: rtl/rgbw_pkg.sv
// Shared constants for the RGBW PWM output stage.
package rgbw_pkg;

    localparam int unsigned DUTY_W_DEF  = 8;
    localparam int unsigned PRESC_W_DEF = 4;
    localparam logic [7:0]  PWM_CNT_MAX = 8'd254;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow register plus registered comparator.
module pwm_channel
    import rgbw_pkg::*;
#(
    parameter int unsigned DUTY_W = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              load,
    input  logic [DUTY_W-1:0] cnt,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              pwm
);

    logic [DUTY_W-1:0] duty_sh_q, duty_sh_d;
    logic              pwm_q, pwm_d;

    always_comb begin
        duty_sh_d = load ? duty_in : duty_sh_q;
        // Compare against the shadow in use this cycle; a same-cycle reload applies next clock.
        pwm_d     = run && (cnt < duty_sh_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_sh_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            duty_sh_q <= duty_sh_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/rgbw_pwm_generator.sv
// Four-channel PWM stage with prescaler and period-boundary shadow loading.
module rgbw_pwm_generator
    import rgbw_pkg::*;
#(
    parameter int unsigned DUTY_W  = DUTY_W_DEF,
    parameter int unsigned PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PRESC_W-1:0] presc,
    input  logic [DUTY_W-1:0]  red_in,
    input  logic [DUTY_W-1:0]  green_in,
    input  logic [DUTY_W-1:0]  blue_in,
    input  logic [DUTY_W-1:0]  white_in,
    output logic               pwm_r,
    output logic               pwm_g,
    output logic               pwm_b,
    output logic               pwm_w,
    output logic               period_start
);

    localparam logic [DUTY_W-1:0] CntMax = DUTY_W'(PWM_CNT_MAX);

    logic [DUTY_W-1:0]  cnt_q, cnt_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [PRESC_W-1:0] presc_sh_q, presc_sh_d;
    logic               run_q, run_d;
    logic               ps_q, ps_d;
    logic               tick;
    logic               load;
    logic               chan_run;

    assign tick     = run_q && (pcnt_q == presc_sh_q);
    // enable low wins over a boundary: no load and no period_start.
    assign load     = enable && (!run_q || (tick && (cnt_q == CntMax)));
    assign chan_run = enable && run_q;

    always_comb begin
        cnt_d      = cnt_q;
        pcnt_d     = pcnt_q;
        run_d      = run_q;
        ps_d       = 1'b0;
        presc_sh_d = load ? presc : presc_sh_q;
        if (!enable) begin
            run_d  = 1'b0;
            cnt_d  = '0;
            pcnt_d = '0;
        end else if (!run_q) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            pcnt_d = '0;
            ps_d   = 1'b1;
        end else begin
            pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
            if (tick) begin
                if (cnt_q == CntMax) begin
                    cnt_d = '0;
                    ps_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + DUTY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            pcnt_q     <= '0;
            presc_sh_q <= '0;
            run_q      <= 1'b0;
            ps_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            presc_sh_q <= presc_sh_d;
            run_q      <= run_d;
            ps_q       <= ps_d;
        end
    end

    assign period_start = ps_q;

    pwm_channel #(.DUTY_W(DUTY_W)) u_chan_r (
        .clk(clk), .reset(reset), .run(chan_run), .load(load),
        .cnt(cnt_q), .duty_in(red_in), .pwm(pwm_r)
    );
    pwm_channel #(.DUTY_W(DUTY_W)) u_chan_g (
        .clk(clk), .reset(reset), .run(chan_run), .load(load),
        .cnt(cnt_q), .duty_in(green_in), .pwm(pwm_g)
    );
    pwm_channel #(.DUTY_W(DUTY_W)) u_chan_b (
        .clk(clk), .reset(reset), .run(chan_run), .load(load),
        .cnt(cnt_q), .duty_in(blue_in), .pwm(pwm_b)
    );
    pwm_channel #(.DUTY_W(DUTY_W)) u_chan_w (
        .clk(clk), .reset(reset), .run(chan_run), .load(load),
        .cnt(cnt_q), .duty_in(white_in), .pwm(pwm_w)
    );

endmodule

// File: tb/tb_rgbw_pwm_generator.sv
// Directed self-checking bench for rgbw_pwm_generator.
module tb_rgbw_pwm_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] presc;
    logic [7:0] red_in, green_in, blue_in, white_in;
    logic       pwm_r, pwm_g, pwm_b, pwm_w, period_start;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int p;
        int r, g, b, w;
        int len;
        int er, eg, eb, ew;
        int ewrun;
    } vec_t;

    vec_t vecs[3];

    rgbw_pwm_generator #(.DUTY_W(8), .PRESC_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .presc(presc),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .white_in(white_in),
        .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .pwm_w(pwm_w),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({period_start, pwm_r, pwm_g, pwm_b, pwm_w});
    endfunction

    // Count high clocks per output over n clocks, plus longest pwm_w high run.
    task automatic run_window(input int n, output int hr, output int hg, output int hb,
                              output int hw, output int ps, output int wrun);
        int cur;
        hr = 0; hg = 0; hb = 0; hw = 0; ps = 0; wrun = 0; cur = 0;
        for (int i = 0; i < n; i++) begin
            step();
            hr += int'(pwm_r);
            hg += int'(pwm_g);
            hb += int'(pwm_b);
            hw += int'(pwm_w);
            ps += int'(period_start);
            cur = pwm_w ? cur + 1 : 0;
            if (cur > wrun) wrun = cur;
        end
    endtask

    // Reset, release, and land just after the first (start) edge.
    task automatic restart(input string name);
        enable = 1'b1;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        step();
        check({name, "_start_ps"}, int'(period_start), 1);
    endtask

    initial begin
        int hr, hg, hb, hw, ps, wrun, hw2;

        vecs[0] = '{p: 0, r: 0,   g: 255, b: 1,   w: 128, len: 255,
                    er: 0,    eg: 255, eb: 1,   ew: 128,  ewrun: 128};
        vecs[1] = '{p: 3, r: 255, g: 200, b: 0,   w: 10,  len: 1020,
                    er: 1020, eg: 800, eb: 0,   ew: 40,   ewrun: 40};
        vecs[2] = '{p: 1, r: 50,  g: 100, b: 254, w: 3,   len: 510,
                    er: 100,  eg: 200, eb: 508, ew: 6,    ewrun: 6};

        reset = 1'b1; enable = 1'b1; presc = 4'd0;
        red_in = 8'h80; green_in = 8'h80; blue_in = 8'h80; white_in = 8'h80;

        // Reset holds everything low even with enable high.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outs", outs(), 0);
        end
        reset = 1'b0;
        step();
        check("rel_ps", int'(period_start), 1);
        check("rel_pwm_low", int'({pwm_r, pwm_g, pwm_b, pwm_w}), 0);
        step();
        check("rel_pwm_high", int'({pwm_r, pwm_g, pwm_b, pwm_w}), 4'hf);
        check("rel_ps_drop", int'(period_start), 0);

        // Table: two full periods per vector.
        for (int v = 0; v < 3; v++) begin
            presc    = 4'(vecs[v].p);
            red_in   = 8'(vecs[v].r);
            green_in = 8'(vecs[v].g);
            blue_in  = 8'(vecs[v].b);
            white_in = 8'(vecs[v].w);
            restart($sformatf("vec%0d", v));
            for (int k = 0; k < 2; k++) begin
                run_window(vecs[v].len, hr, hg, hb, hw, ps, wrun);
                check($sformatf("vec%0d_p%0d_r", v, k), hr, vecs[v].er);
                check($sformatf("vec%0d_p%0d_g", v, k), hg, vecs[v].eg);
                check($sformatf("vec%0d_p%0d_b", v, k), hb, vecs[v].eb);
                check($sformatf("vec%0d_p%0d_w", v, k), hw, vecs[v].ew);
                check($sformatf("vec%0d_p%0d_wrun", v, k), wrun, vecs[v].ewrun);
                check($sformatf("vec%0d_p%0d_ps", v, k), ps, 1);
                check($sformatf("vec%0d_p%0d_ps_end", v, k), int'(period_start), 1);
            end
        end

        // Mid-period duty change: current period keeps 128, next gets 20.
        presc = 4'd0; red_in = 8'd0; green_in = 8'd0; blue_in = 8'd0; white_in = 8'd128;
        restart("mid");
        run_window(50, hr, hg, hb, hw, ps, wrun);
        white_in = 8'd20;
        run_window(205, hr, hg, hb, hw2, ps, wrun);
        check("mid_cur_w", hw + hw2, 128);
        check("mid_cur_ps", ps, 1);
        run_window(255, hr, hg, hb, hw, ps, wrun);
        check("mid_next_w", hw, 20);

        // Mid-period presc change waits for the boundary.
        white_in = 8'd128;
        restart("presc");
        presc = 4'd1;
        run_window(255, hr, hg, hb, hw, ps, wrun);
        check("presc_old_w", hw, 128);
        check("presc_old_ps", int'(period_start), 1);
        run_window(510, hr, hg, hb, hw, ps, wrun);
        check("presc_new_w", hw, 256);
        check("presc_new_ps", ps, 1);
        presc = 4'd0;

        // enable dropped mid-period while pwm_w is high.
        restart("en");
        for (int i = 0; i < 100; i++) step();
        check("en_w_high", int'(pwm_w), 1);
        enable = 1'b0;
        step();
        check("en_off_outs", outs(), 0);
        for (int i = 0; i < 3; i++) step();
        check("en_off_hold", outs(), 0);
        enable = 1'b1;
        step();
        check("en_re_ps", int'(period_start), 1);
        check("en_re_pwm_low", int'(pwm_w), 0);
        run_window(255, hr, hg, hb, hw, ps, wrun);
        check("en_re_w", hw, 128);
        check("en_re_ps_cnt", ps, 1);

        // enable falling in the boundary cycle suppresses the load.
        restart("bnd");
        for (int i = 0; i < 254; i++) step();
        enable = 1'b0;
        step();
        check("bnd_no_ps", outs(), 0);
        enable = 1'b1;
        step();
        check("bnd_restart_ps", int'(period_start), 1);

        // Async reset between edges drops outputs without a clock edge.
        restart("async");
        for (int i = 0; i < 60; i++) step();
        check("async_w_high", int'(pwm_w), 1);
        #3 reset = 1'b1;
        #1 check("async_outs", outs(), 0);
        #2 reset = 1'b0;
        step();
        check("async_rel_ps", int'(period_start), 1);
        run_window(255, hr, hg, hb, hw, ps, wrun);
        check("async_rel_w", hw, 128);
        check("async_rel_wrun", wrun, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgbw_pwm_generator.md
Name: rgbw_pwm_generator

Overview:
- Four-channel PWM output stage that sits directly downstream of the colour wheel processor.
- Consumes its registered red/green/blue/white levels and drives the LED driver pins.
- Duty values are shadow-latched only at period boundaries, so upstream updates (which land at arbitrary times) never cause glitched or truncated pulses.
- A programmable prescaler sets the PWM frequency.

Parameters:
- DUTY_W, 8, width of the duty inputs and of the period counter.
- PRESC_W, 4, width of the prescaler divide input.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run control; low stops the PWM and forces the outputs low.
- presc  in  PRESC_W  divide value; one counter tick every presc+1 clocks.
- red_in  in  DUTY_W  red duty (0 = off, 255 = fully on).
- green_in  in  DUTY_W  green duty.
- blue_in  in  DUTY_W  blue duty.
- white_in  in  DUTY_W  white duty.
- pwm_r  out  1  red PWM.
- pwm_g  out  1  green PWM.
- pwm_b  out  1  blue PWM.
- pwm_w  out  1  white PWM.
- period_start  out  1  one-clock pulse in the cycle the shadows load.

Behaviour:
- Reset (async, active-high):
  - cnt=0, pcnt=0, run=0.
  - All duty shadows and presc_sh = 0.
  - pwm_r/g/b/w = 0, period_start = 0.
  - Reset asserted mid-period aborts immediately. After release the generator behaves exactly as from power-up.
- enable=0 (synchronous):
  - run<=0, cnt<=0, pcnt<=0.
  - All pwm outputs <= 0, period_start <= 0.
  - Shadows hold their values.
- Start, on a clock with enable=1 and run=0:
  - Load all four duty shadows from the *_in ports and presc_sh from presc.
  - cnt<=0, pcnt<=0, run<=1, period_start<=1.
- Running, on a clock with enable=1 and run=1:
  - Prescaler: if pcnt==presc_sh then pcnt<=0 and tick=1; else pcnt<=pcnt+1.
  - On tick with cnt==254: cnt<=0, reload all shadows and presc_sh, period_start<=1.
  - On tick with cnt<254: cnt<=cnt+1.
  - On all other clocks, period_start<=0.
- Period:
  - 255 counter steps (0..254).
  - 255*(presc_sh+1) clocks per period.
- Compare, every clock while running: pwm_x <= (cnt < duty_x_sh), unsigned.
  - duty 0: output never high.
  - duty 255: output always high, with no gap at the wrap.
  - duty d: high for exactly d*(presc_sh+1) clocks per period.
- Latency:
  - Outputs are registered and reflect the cnt/shadow values of the previous clock.
  - The first high output appears one clock after period_start.
- Input changes:
  - Duty inputs changed mid-period are ignored until the next shadow load. Only the value present in the load cycle is used.
  - presc changed mid-period takes effect only at the next boundary.
- Simultaneous events:
  - reset dominates everything.
  - enable falling in a boundary cycle takes priority: no load occurs and period_start stays 0.
- Counter wrap: pcnt never exceeds presc_sh, and cnt never reaches 255.

Decomposition:
- Shared package (rgbw_pkg) holds:
  - PWM_CNT_MAX = 8'd254.
  - Default DUTY_W and PRESC_W.
- One sub-module, pwm_channel:
  - Contains one duty shadow register and the registered comparator.
  - Inputs: clk, reset, run, load, cnt, duty_in. Output: pwm.
  - Instantiated four times.
- Prescaler, period counter and run/load control stay in the top module.

Test Plan:
- Reset and outputs:
  - Assert reset with enable=1 and all duties=8'h80 → all outputs 0 and period_start=0 while reset is high.
  - Release reset → period_start pulses on the first clock; pwm outputs go high on the next clock.
- presc=0, red=0, green=255, blue=1, white=128, run 2 periods →
  - pwm_r never high.
  - pwm_g continuously high.
  - pwm_b high 1 clock per 255.
  - pwm_w high 128 clocks then low 127.
  - period_start every 255 clocks.
- presc=3, white=10 → period 1020 clocks, pwm_w high 40 consecutive clocks per period.
- Mid-period duty change: white 128→20 at cnt=50 → current period still 128 high clocks; the next period (after period_start) has 20.
- enable dropped at cnt=100 while pwm_w is high →
  - All outputs 0 on the next clock.
  - Re-enabling restarts a full period with period_start on the first enabled clock.
- Async reset asserted between clock edges mid-period → outputs drop without waiting for a clock edge; cnt restarts at 0 after release.
